io_timer: RTL and testbench

- Memory-mapped down-counting timer on the CPU's DMA I/O bus (dma_io_*), instantiated in fpga_top next to io_led.
- Sits upstream of io_led in the read-data daisy chain: its dma_io_rdata output feeds io_led's dma_io_rdata_in, replacing today's constant-zero tie-off.
- Its irq output drives cpu_top's interrupt_0, ORed with the external pin at top level.

---
 rtl/io_timer_pkg.sv | 38 +++
 rtl/io_timer_prescaler.sv | 39 +++
 rtl/io_timer.sv | 194 +++++++++++++++++++
 tb/tb_io_timer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_timer_pkg.sv
// Shared I/O map for the DMA I/O bus: block base addresses, timer register offsets
// and CTRL/STATUS bit positions, used by io_timer, io_led and the CPU-side constants.
package io_timer_pkg;

    localparam logic [13:0] IO_TIMER_BASE_ADR = 14'h3E00;
    localparam logic [13:0] IO_LED_BASE_ADR   = 14'h3F00;

    localparam int unsigned IO_TIMER_NUM_REGS = 6;

    typedef enum logic [2:0] {
        REG_CTRL     = 3'd0,
        REG_STATUS   = 3'd1,
        REG_LOAD     = 3'd2,
        REG_COUNT    = 3'd3,
        REG_PRESCALE = 3'd4,
        REG_CAPTURE  = 3'd5
    } io_timer_reg_e;

    localparam int CTRL_EN_BIT         = 0;
    localparam int CTRL_AUTORELOAD_BIT = 1;
    localparam int CTRL_IRQ_EN_BIT     = 2;
    localparam int STATUS_EXPIRED_BIT  = 0;
    localparam int STATUS_CAPTURED_BIT = 1;

    // True when a word address falls inside the timer's register window.
    function automatic logic reg_hit(input logic [13:0] adr, input logic [13:0] base);
        logic [13:0] diff;
        diff = adr - base;
        return (diff < 14'(IO_TIMER_NUM_REGS));
    endfunction

    function automatic logic [2:0] reg_offset(input logic [13:0] adr, input logic [13:0] base);
        logic [13:0] diff;
        diff = adr - base;
        return diff[2:0];
    endfunction

endpackage

// File: rtl/io_timer_prescaler.sv
// Prescaler for io_timer: emits a one-cycle tick every (prescale+1) enabled cycles.
// The count is held at 0 while disabled, so every 0->1 enable restarts from 0.
module io_timer_prescaler #(
    parameter int PRE_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [PRE_W-1:0] prescale,
    output logic             tick
);

    logic [PRE_W-1:0] pre_cnt_q;
    logic [PRE_W-1:0] pre_cnt_d;

    assign tick = en & (pre_cnt_q == prescale);

    // Next prescaler count: hold at zero when disabled, wrap to zero on tick.
    always_comb begin
        pre_cnt_d = pre_cnt_q;
        if (!en) begin
            pre_cnt_d = {PRE_W{1'b0}};
        end else if (tick) begin
            pre_cnt_d = {PRE_W{1'b0}};
        end else begin
            pre_cnt_d = pre_cnt_q + {{(PRE_W-1){1'b0}}, 1'b1};
        end
    end

    // Prescaler count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt_q <= {PRE_W{1'b0}};
        end else begin
            pre_cnt_q <= pre_cnt_d;
        end
    end

endmodule

// File: rtl/io_timer.sv
// Memory-mapped down-counting timer on the DMA I/O bus with a registered read-data
// daisy-chain contribution and level irq. Optional input capture: IO_TIMER_CAPTURE_EN.
module io_timer
    import io_timer_pkg::*;
#(
    parameter logic [13:0] BASE_ADR = IO_TIMER_BASE_ADR,
    parameter int          PRE_W    = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dma_io_we,
    input  logic [13:0] dma_io_wadr,
    input  logic [31:0] dma_io_wdata,
    input  logic [13:0] dma_io_radr,
    input  logic [31:0] dma_io_rdata_in,
    output logic [31:0] dma_io_rdata,
    input  logic        cap_in,
    output logic        irq
);

    logic             en_q, en_d;
    logic             autoreload_q, autoreload_d;
    logic             irq_en_q, irq_en_d;
    logic             expired_q, expired_d;
    logic             captured_q, captured_d;
    logic             irq_q, irq_d;
    logic [31:0]      load_q, load_d;
    logic [31:0]      count_q, count_d;
    logic [31:0]      capture_q, capture_d;
    logic [31:0]      own_q, own_d;
    logic [PRE_W-1:0] prescale_q, prescale_d;

    logic       tick_s;
    logic       tick_eff_s;
    logic       count_zero_s;
    logic       expire_set_s;
    logic       cap_edge_s;
    logic       wr_hit_s;
    logic [2:0] wsel_s;
    logic       wr_ctrl_s, wr_status_s, wr_load_s, wr_count_s, wr_prescale_s;
    logic       rd_hit_s;
    logic [2:0] rsel_s;

    io_timer_prescaler #(
        .PRE_W (PRE_W)
    ) u_prescaler (
        .clk      (clk),
        .rst      (rst),
        .en       (en_q),
        .prescale (prescale_q),
        .tick     (tick_s)
    );

`ifdef IO_TIMER_CAPTURE_EN
    logic [2:0] cap_sync_q;

    // Two-flop synchronizer plus one delay flop for rising-edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_sync_q <= 3'b000;
        end else begin
            cap_sync_q <= {cap_sync_q[1:0], cap_in};
        end
    end

    assign cap_edge_s = cap_sync_q[1] & ~cap_sync_q[2];
`else
    logic unused_cap_s;
    assign unused_cap_s = cap_in;
    assign cap_edge_s   = 1'b0;
`endif

    assign wr_hit_s      = dma_io_we & reg_hit(dma_io_wadr, BASE_ADR);
    assign wsel_s        = reg_offset(dma_io_wadr, BASE_ADR);
    assign wr_ctrl_s     = wr_hit_s & (wsel_s == REG_CTRL);
    assign wr_status_s   = wr_hit_s & (wsel_s == REG_STATUS);
    assign wr_load_s     = wr_hit_s & (wsel_s == REG_LOAD);
    assign wr_count_s    = wr_hit_s & (wsel_s == REG_COUNT);
    assign wr_prescale_s = wr_hit_s & (wsel_s == REG_PRESCALE);

    assign rd_hit_s = reg_hit(dma_io_radr, BASE_ADR);
    assign rsel_s   = reg_offset(dma_io_radr, BASE_ADR);

    // A COUNT write swallows the whole tick, including any expiry it would cause.
    assign tick_eff_s   = tick_s & ~wr_count_s;
    assign count_zero_s = (count_q == 32'd0);
    assign expire_set_s = tick_eff_s & count_zero_s;

    // Register-file and counter next-state; bus writes take priority over the tick.
    always_comb begin
        en_d         = en_q;
        autoreload_d = autoreload_q;
        irq_en_d     = irq_en_q;
        load_d       = load_q;
        count_d      = count_q;
        prescale_d   = prescale_q;
        capture_d    = capture_q;

        if (wr_ctrl_s) begin
            en_d         = dma_io_wdata[CTRL_EN_BIT];
            autoreload_d = dma_io_wdata[CTRL_AUTORELOAD_BIT];
            irq_en_d     = dma_io_wdata[CTRL_IRQ_EN_BIT];
        end else if (expire_set_s && !autoreload_q) begin
            en_d = 1'b0;
        end else begin
            en_d = en_q;
        end

        if (wr_count_s) begin
            count_d = dma_io_wdata;
        end else if (tick_eff_s && !count_zero_s) begin
            count_d = count_q - 32'd1;
        end else if (expire_set_s && autoreload_q) begin
            count_d = load_q;
        end else begin
            count_d = count_q;
        end

        if (wr_load_s) begin
            load_d = dma_io_wdata;
        end else begin
            load_d = load_q;
        end

        if (wr_prescale_s) begin
            prescale_d = dma_io_wdata[PRE_W-1:0];
        end else begin
            prescale_d = prescale_q;
        end

        if (cap_edge_s) begin
            capture_d = count_q;
        end else begin
            capture_d = capture_q;
        end

        expired_d  = (expired_q & ~(wr_status_s & dma_io_wdata[STATUS_EXPIRED_BIT]))
                   | expire_set_s;
        captured_d = (captured_q & ~(wr_status_s & dma_io_wdata[STATUS_CAPTURED_BIT]))
                   | cap_edge_s;
        irq_d      = expired_q & irq_en_q;
    end

    // Own read-data mux; zero when the read address misses this block.
    always_comb begin
        own_d = 32'd0;
        if (rd_hit_s) begin
            case (rsel_s)
                REG_CTRL:     own_d = {29'd0, irq_en_q, autoreload_q, en_q};
                REG_STATUS:   own_d = {30'd0, captured_q, expired_q};
                REG_LOAD:     own_d = load_q;
                REG_COUNT:    own_d = count_q;
                REG_PRESCALE: own_d = 32'(prescale_q);
                REG_CAPTURE:  own_d = capture_q;
                default:      own_d = 32'd0;
            endcase
        end else begin
            own_d = 32'd0;
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            en_q         <= 1'b0;
            autoreload_q <= 1'b0;
            irq_en_q     <= 1'b0;
            expired_q    <= 1'b0;
            captured_q   <= 1'b0;
            irq_q        <= 1'b0;
            load_q       <= 32'd0;
            count_q      <= 32'd0;
            capture_q    <= 32'd0;
            own_q        <= 32'd0;
            prescale_q   <= {PRE_W{1'b0}};
        end else begin
            en_q         <= en_d;
            autoreload_q <= autoreload_d;
            irq_en_q     <= irq_en_d;
            expired_q    <= expired_d;
            captured_q   <= captured_d;
            irq_q        <= irq_d;
            load_q       <= load_d;
            count_q      <= count_d;
            capture_q    <= capture_d;
            own_q        <= own_d;
            prescale_q   <= prescale_d;
        end
    end

    assign dma_io_rdata = dma_io_rdata_in | own_q;
    assign irq          = irq_q;

endmodule

// File: tb/tb_io_timer.sv
// Directed self-checking bench for io_timer: register access, read chain, one-shot,
// autoreload, same-cycle collisions, capture (build-dependent) and mid-run reset.
module tb_io_timer;

    localparam logic [13:0] BASE = 14'h3E00;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [13:0] wadr;
    logic [31:0] wdata;
    logic [13:0] radr;
    logic [31:0] rdata_in;
    logic [31:0] rdata;
    logic        cap_in;
    logic        irq;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    io_timer dut (
        .clk             (clk),
        .rst             (rst),
        .dma_io_we       (we),
        .dma_io_wadr     (wadr),
        .dma_io_wdata    (wdata),
        .dma_io_radr     (radr),
        .dma_io_rdata_in (rdata_in),
        .dma_io_rdata    (rdata),
        .cap_in          (cap_in),
        .irq             (irq)
    );

    task automatic wr(input logic [2:0] off, input logic [31:0] d);
        @(negedge clk);
        we    = 1'b1;
        wadr  = BASE + 14'(off);
        wdata = d;
        @(negedge clk);
        we    = 1'b0;
    endtask

    task automatic rd(input logic [2:0] off, output logic [31:0] d);
        @(negedge clk);
        radr = BASE + 14'(off);
        @(posedge clk);
        #1;
        d = rdata;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rst = 1'b1; we = 1'b0; wadr = 14'd0; wdata = 32'd0;
        radr = 14'd0; rdata_in = 32'd0; cap_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq got %b want 0", irq); end
        n_vec++; if (rdata !== 32'd0) begin n_err++; $display("FAIL reset_rdata got %h want 0", rdata); end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            rd(3'(i), d);
            n_vec++; if (d !== 32'd0) begin n_err++; $display("FAIL reset_reg%0d got %h want 0", i, d); end
        end
        rdata_in = 32'hA5A5_0000;
        @(negedge clk); radr = BASE + 14'd6;
        @(posedge clk); #1;
        n_vec++; if (rdata !== 32'hA5A5_0000) begin n_err++; $display("FAIL chain_miss6 got %h want a5a50000", rdata); end
        @(negedge clk); radr = 14'h0000;
        @(posedge clk); #1;
        n_vec++; if (rdata !== 32'hA5A5_0000) begin n_err++; $display("FAIL chain_miss0 got %h want a5a50000", rdata); end
    endtask

    task automatic test_regs();
        logic [31:0] d;
        wr(3'd2, 32'h0000_1234);
        rd(3'd2, d);
        n_vec++; if (d !== 32'hA5A5_1234) begin n_err++; $display("FAIL chain_or got %h want a5a51234", d); end
        rdata_in = 32'd0;
        wr(3'd2, 32'hDEAD_BEEF);
        rd(3'd2, d);
        n_vec++; if (d !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL load_rw got %h want deadbeef", d); end
        wr(3'd0, 32'hFFFF_FFF8);
        rd(3'd0, d);
        n_vec++; if (d !== 32'd0) begin n_err++; $display("FAIL ctrl_unused got %h want 0", d); end
        wr(3'd4, 32'hFFFF_0007);
        rd(3'd4, d);
        n_vec++; if (d !== 32'h0000_0007) begin n_err++; $display("FAIL prescale_w got %h want 7", d); end
        wr(3'd5, 32'h1234_5678);
        rd(3'd5, d);
        n_vec++; if (d !== 32'd0) begin n_err++; $display("FAIL capture_ro got %h want 0", d); end
        wr(3'd4, 32'd0);
        wr(3'd2, 32'd0);
    endtask

    task automatic test_one_shot();
        logic [31:0] d;
        logic [31:0] exp_cnt [5] = '{32'd3, 32'd2, 32'd1, 32'd0, 32'd0};
        wr(3'd4, 32'd0);
        wr(3'd3, 32'd3);
        radr = BASE + 14'd3;
        wr(3'd0, 32'd5);
        for (int k = 2; k <= 6; k++) begin
            @(posedge clk); #1;
            n_vec++;
            if (rdata !== exp_cnt[k-2]) begin n_err++; $display("FAIL oneshot_cnt k%0d got %h want %h", k, rdata, exp_cnt[k-2]); end
            n_vec++;
            if (irq !== (k == 6)) begin n_err++; $display("FAIL oneshot_irq k%0d got %b want %b", k, irq, (k == 6)); end
        end
        rd(3'd0, d);
        n_vec++; if (d !== 32'd4) begin n_err++; $display("FAIL oneshot_ctrl got %h want 4", d); end
        rd(3'd1, d);
        n_vec++; if (d !== 32'd1) begin n_err++; $display("FAIL oneshot_status got %h want 1", d); end
        repeat (3) @(negedge clk);
        rd(3'd3, d);
        n_vec++; if (d !== 32'd0) begin n_err++; $display("FAIL oneshot_hold got %h want 0", d); end
    endtask

    task automatic test_autoreload();
        logic        chk_c, chk_i, e_i;
        logic [31:0] e_c;
        wr(3'd1, 32'd1);
        wr(3'd4, 32'd4);
        wr(3'd2, 32'd1);
        wr(3'd3, 32'd1);
        radr = BASE + 14'd3;
        wr(3'd0, 32'd7);
        for (int k = 2; k <= 22; k++) begin
            @(posedge clk); #1;
            chk_c = 1'b1; e_c = 32'd0;
            case (k)
                6, 12, 16, 22: e_c = 32'd1;
                7, 11, 17, 21: e_c = 32'd0;
                default:       chk_c = 1'b0;
            endcase
            chk_i = 1'b1; e_i = 1'b0;
            case (k)
                12, 14, 22:    e_i = 1'b1;
                11, 15, 20, 21: e_i = 1'b0;
                default:       chk_i = 1'b0;
            endcase
            if (chk_c) begin
                n_vec++;
                if (rdata !== e_c) begin n_err++; $display("FAIL reload_cnt k%0d got %h want %h", k, rdata, e_c); end
            end
            if (chk_i) begin
                n_vec++;
                if (irq !== e_i) begin n_err++; $display("FAIL reload_irq k%0d got %b want %b", k, irq, e_i); end
            end
            if (k == 13) begin
                we = 1'b1; wadr = BASE + 14'd1; wdata = 32'd1;
            end
            if (k == 14) we = 1'b0;
        end
        wr(3'd0, 32'd0);
        wr(3'd1, 32'd1);
    endtask

    task automatic test_collisions();
        logic [31:0] d;
        wr(3'd4, 32'd0);
        wr(3'd3, 32'd50);
        wr(3'd0, 32'd1);
        radr = BASE + 14'd3;
        wr(3'd3, 32'd100);
        @(posedge clk); #1;
        n_vec++; if (rdata !== 32'd100) begin n_err++; $display("FAIL count_wr_tick got %0d want 100", rdata); end
        @(posedge clk); #1;
        n_vec++; if (rdata !== 32'd99) begin n_err++; $display("FAIL count_after_wr got %0d want 99", rdata); end

        wr(3'd0, 32'd0);
        wr(3'd1, 32'd1);
        wr(3'd3, 32'd2);
        wr(3'd0, 32'd1);
        @(negedge clk);
        wr(3'd1, 32'd1);
        rd(3'd1, d);
        n_vec++; if (d !== 32'd1) begin n_err++; $display("FAIL clr_vs_expire got %h want 1", d); end
        rd(3'd0, d);
        n_vec++; if (d !== 32'd0) begin n_err++; $display("FAIL oneshot_stop got %h want 0", d); end

        wr(3'd1, 32'd1);
        wr(3'd3, 32'd2);
        radr = BASE + 14'd0;
        wr(3'd0, 32'd1);
        @(negedge clk);
        wr(3'd0, 32'd1);
        @(posedge clk); #1;
        n_vec++; if (rdata !== 32'd1) begin n_err++; $display("FAIL ctrl_vs_autoclr got %h want 1", rdata); end
        @(posedge clk); #1;
        n_vec++; if (rdata !== 32'd0) begin n_err++; $display("FAIL ctrl_reclear got %h want 0", rdata); end
        wr(3'd1, 32'd1);
    endtask

    task automatic test_capture();
        logic [31:0] d;
        wr(3'd4, 32'd0);
        wr(3'd3, 32'd1000);
        wr(3'd0, 32'd1);
        @(negedge clk);
        @(negedge clk);
        cap_in = 1'b1;
        @(negedge clk);
        cap_in = 1'b0;
        wr(3'd0, 32'd0);
        repeat (4) @(negedge clk);
        rd(3'd5, d);
`ifdef IO_TIMER_CAPTURE_EN
        n_vec++; if (d !== 32'd996) begin n_err++; $display("FAIL capture_val got %0d want 996", d); end
        rd(3'd1, d);
        n_vec++; if (d !== 32'd2) begin n_err++; $display("FAIL capture_flag got %h want 2", d); end
        wr(3'd1, 32'd2);
        rd(3'd1, d);
        n_vec++; if (d !== 32'd0) begin n_err++; $display("FAIL capture_clr got %h want 0", d); end
`else
        n_vec++; if (d !== 32'd0) begin n_err++; $display("FAIL capture_off got %0d want 0", d); end
        rd(3'd1, d);
        n_vec++; if (d !== 32'd0) begin n_err++; $display("FAIL captured_off got %h want 0", d); end
`endif
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        wr(3'd1, 32'd3);
        wr(3'd4, 32'd0);
        wr(3'd2, 32'd5);
        wr(3'd3, 32'd0);
        wr(3'd0, 32'd7);
        radr = BASE + 14'd3;
        repeat (3) @(posedge clk);
        #1;
        n_vec++; if (irq !== 1'b1) begin n_err++; $display("FAIL pre_rst_irq got %b want 1", irq); end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL mid_rst_irq got %b want 0", irq); end
        n_vec++; if (rdata !== 32'd0) begin n_err++; $display("FAIL mid_rst_rdata got %h want 0", rdata); end
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            rd(3'(i), d);
            n_vec++; if (d !== 32'd0) begin n_err++; $display("FAIL post_rst_reg%0d got %h want 0", i, d); end
        end
        n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL post_rst_irq got %b want 0", irq); end
    endtask

    initial begin
        test_reset();
        test_regs();
        test_one_shot();
        test_autoreload();
        test_collisions();
        test_capture();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
